// File: rtl/spi_phy_pkg.sv
// ---------------------------------------------------------------------------
// spi_phy_pkg
// Shared definitions for the SPI flash PHY: FSM state encoding, byte width,
// and the idle/active levels of the mode-0 serial lines.
// ---------------------------------------------------------------------------
package spi_phy_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  // Mode 0: clock idles low, data launched on falling edge, sampled on rising.
  localparam logic SCLK_IDLE   = 1'b0;
  localparam logic CS_ASSERT   = 1'b0;
  localparam logic CS_DEASSERT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_NEXT,
    HOLD,
    DESEL
  } state_e;

endpackage

// File: rtl/spi_clk_tick.sv
// ---------------------------------------------------------------------------
// spi_clk_tick
// Half-period timer for the SPI clock. While enabled it emits a one-cycle
// tick every CLK_DIV cycles; it restarts from zero when cleared or disabled.
// Ports:
//   p_clk, p_rst  system clock, asynchronous active-high reset
//   en            count while high
//   clr           restart the period (byte accept)
//   tick          high on the last cycle of each half-period
// ---------------------------------------------------------------------------
module spi_clk_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic p_clk,
  input  logic p_rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d unassigned, which would infer a latch.
    cnt_d = cnt_q;
    if (clr || !en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_flash_phy.sv
// ---------------------------------------------------------------------------
// spi_flash_phy
// Mode-0, MSB-first SPI engine. Accepts bytes on a valid/ready stream, shifts
// each out on s_mosi while sampling s_miso, and returns one received byte per
// sent byte. Chip select stays low across a burst until a byte tagged tx_last
// completes, then is held high for at least CS_IDLE cycles.
// Ports:
//   p_clk, p_rst              system clock, asynchronous active-high reset
//   tx_valid/tx_ready/tx_data/tx_last  upstream byte stream
//   rx_valid/rx_data          received byte, rx_valid is a one-cycle pulse
//   busy                      engine not in IDLE
//   s_clk/s_css/s_mosi/s_miso SPI bus (s_css active-low)
// ---------------------------------------------------------------------------
module spi_flash_phy
  import spi_phy_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_IDLE = 4
) (
  input  logic       p_clk,
  input  logic       p_rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       s_clk,
  output logic       s_css,
  output logic       s_mosi,
  input  logic       s_miso
);

  localparam int unsigned CS_W = $clog2(CS_IDLE) + 1;
  localparam logic [CS_W-1:0] CS_LOAD = CS_W'(CS_IDLE - 1);
  localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_W - 1);

  state_e                  state_q, state_d;
  logic [SPI_BYTE_W-1:0]   tx_sr_q, tx_sr_d;
  logic [SPI_BYTE_W-2:0]   rx_sr_q, rx_sr_d;   // first seven bits; the eighth comes straight from s_miso
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [CS_W-1:0]         cs_cnt_q, cs_cnt_d;
  logic                    last_q, last_d;
  logic                    s_clk_q, s_clk_d;
  logic                    s_css_q, s_css_d;
  logic                    s_mosi_q, s_mosi_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [SPI_BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                    busy_q, busy_d;

  logic accept;
  logic tick;

  assign accept = tx_valid && tx_ready_q;

  // HOLD reuses the half-period timer so CS trails the last falling edge by CLK_DIV cycles.
  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .p_clk (p_clk),
    .p_rst (p_rst),
    .en    ((state_q == SHIFT) || (state_q == HOLD)),
    .clr   (accept),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    cs_cnt_d   = cs_cnt_q;
    last_d     = last_q;
    s_clk_d    = s_clk_q;
    s_css_d    = s_css_q;
    s_mosi_d   = s_mosi_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    case (state_q)
      IDLE, WAIT_NEXT: begin
        if (accept) begin
          // The first low phase after this edge doubles as CS setup time.
          state_d   = SHIFT;
          tx_sr_d   = tx_data;
          last_d    = tx_last;
          bit_cnt_d = '0;
          s_clk_d   = SCLK_IDLE;
          s_css_d   = CS_ASSERT;
          s_mosi_d  = tx_data[SPI_BYTE_W-1];
        end
      end

      SHIFT: begin
        if (tick) begin
          if (!s_clk_q) begin
            s_clk_d = 1'b1;
          end else begin
            // Falling edge: sample s_miso, then launch the next bit.
            s_clk_d = 1'b0;
            rx_sr_d = {rx_sr_q[SPI_BYTE_W-3:0], s_miso};
            if (bit_cnt_q == LAST_BIT) begin
              rx_valid_d = 1'b1;
              rx_data_d  = {rx_sr_q, s_miso};
              state_d    = last_q ? HOLD : WAIT_NEXT;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_sr_d   = tx_sr_q << 1;
              s_mosi_d  = tx_sr_q[SPI_BYTE_W-2];
            end
          end
        end
      end

      HOLD: begin
        if (tick) begin
          state_d  = DESEL;
          s_css_d  = CS_DEASSERT;
          s_mosi_d = 1'b0;
          cs_cnt_d = CS_LOAD;
        end
      end

      DESEL: begin
        if (cs_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cs_cnt_d = cs_cnt_q - CS_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered from the next state so ready is already high in the first WAIT_NEXT cycle.
    tx_ready_d = (state_d == IDLE) || (state_d == WAIT_NEXT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      cs_cnt_q   <= '0;
      last_q     <= 1'b0;
      s_clk_q    <= SCLK_IDLE;
      s_css_q    <= CS_DEASSERT;
      s_mosi_q   <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      cs_cnt_q   <= cs_cnt_d;
      last_q     <= last_d;
      s_clk_q    <= s_clk_d;
      s_css_q    <= s_css_d;
      s_mosi_q   <= s_mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign s_clk    = s_clk_q;
  assign s_css    = s_css_q;
  assign s_mosi   = s_mosi_q;

endmodule

// File: tb/tb_spi_flash_phy.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_phy
// Bench for spi_flash_phy: a CLK_DIV=2 instance driven from a vector table
// and hand-written corner sequences, plus a CLK_DIV=1 instance for byte time.
// A behavioural mode-0 flash returns queued bytes on s_miso; expected rx
// bytes, mosi bits and accept times are queued when a byte is offered and
// popped by a monitor when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_spi_flash_phy;

  localparam int DIV = 2;
  localparam int PER = 10;

  logic       p_clk = 1'b0;
  logic       p_rst = 1'b1;

  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, busy, s_clk, s_css, s_mosi;
  logic [7:0] rx_data;
  logic       s_miso = 1'b0;

  logic       tx_valid1 = 1'b0, tx_last1 = 1'b0;
  logic [7:0] tx_data1 = 8'h00;
  logic       tx_ready1, rx_valid1, busy1, s_clk1, s_css1, s_mosi1;
  logic [7:0] rx_data1;
  logic       s_miso1 = 1'b1;

  always #(PER/2) p_clk = ~p_clk;

  spi_flash_phy #(.CLK_DIV(DIV), .CS_IDLE(4)) dut (
    .p_clk(p_clk), .p_rst(p_rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .s_clk(s_clk), .s_css(s_css), .s_mosi(s_mosi), .s_miso(s_miso)
  );

  spi_flash_phy #(.CLK_DIV(1), .CS_IDLE(4)) dut1 (
    .p_clk(p_clk), .p_rst(p_rst),
    .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1), .tx_last(tx_last1),
    .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1),
    .s_clk(s_clk1), .s_css(s_css1), .s_mosi(s_mosi1), .s_miso(s_miso1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Scoreboard queues
  logic       exp_mosi[$];
  logic [7:0] exp_rx[$];
  logic [7:0] miso_q[$];
  longint     acc_q[$];
  longint     last_rx_t = 0;

  // Mode-0 flash: byte loaded at the first rising edge, next bit on each falling edge.
  logic [7:0] fl_sr = 8'h00;
  int         fl_bits = 0;

  always @(posedge s_css or negedge s_css) fl_bits = 0;

  always @(posedge s_clk) begin
    if (fl_bits == 0) begin
      fl_sr = 8'h00;
      if (miso_q.size() > 0) fl_sr = miso_q.pop_front();
      s_miso = fl_sr[7];
    end
  end

  always @(negedge s_clk) begin
    if (!s_css) begin
      fl_bits++;
      if (fl_bits == 8) fl_bits = 0;
      fl_sr  = fl_sr << 1;
      s_miso = fl_sr[7];
    end
  end

  // Monitor, sampled on the falling p_clk edge
  logic s_clk_prev = 1'b0;
  int   rise_cnt = 0, rx_cnt = 0;
  int   cs_low_run = 0, cs_low_len = 0, cs_high_run = 0, cs_high_len = 0;

  always @(negedge p_clk) begin
    if (s_clk && !s_clk_prev) begin
      rise_cnt++;
      if (exp_mosi.size() == 0) fail_now("mosi_unexpected_rise");
      else check("mosi_at_rise", s_mosi, exp_mosi.pop_front());
    end
    s_clk_prev = s_clk;

    if (rx_valid) begin
      rx_cnt++;
      last_rx_t = $time - PER/2;
      if (exp_rx.size() == 0) fail_now("rx_unexpected");
      else check("rx_data", rx_data, exp_rx.pop_front());
      if (acc_q.size() > 0) check("byte_time", 32'((last_rx_t - acc_q.pop_front()) / PER), 16*DIV);
    end

    if (!s_css) begin
      if (cs_high_run > 0) cs_high_len = cs_high_run;
      cs_high_run = 0;
      cs_low_run++;
    end else begin
      if (cs_low_run > 0) cs_low_len = cs_low_run;
      cs_low_run = 0;
      cs_high_run++;
    end

    if (s_css && busy) check("desel_not_ready", tx_ready, 1'b0);
  end

  // Offer one byte at a falling edge; returns on the falling edge after acceptance.
  task automatic offer(input logic [7:0] d, input logic l, input logic [7:0] m,
                       input logic [7:0] er, input logic chk_gap);
    longint t;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    miso_q.push_back(m);
    exp_rx.push_back(er);
    for (int b = 7; b >= 0; b--) exp_mosi.push_back(d[b]);
    for (int c = 0; c < 500 && !tx_ready; c++) @(negedge p_clk);
    if (!tx_ready) begin
      fail_now("accept_wait");
      tx_valid = 1'b0;
      return;
    end
    @(posedge p_clk);
    t = $time;
    acc_q.push_back(t);
    if (chk_gap) check("burst_gap", 32'((t - last_rx_t) / PER), 1);
    @(negedge p_clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    @(negedge p_clk);
    for (int c = 0; c < 2000 && busy; c++) @(negedge p_clk);
    if (busy) fail_now(name);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       last;
    logic [7:0] miso;
    int         gap;      // extra idle cycles in WAIT_NEXT before this byte
    logic       chk_gap;  // expect exactly one cycle between previous rx_valid and this accept
    logic [7:0] exp_rx;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   n_b, gap_sum, base_rx, base_rise;
    longint t0, t_rx;
    int   lo1, ri1;
    logic prev1;
    logic [7:0] mosi1;

    // single byte; held-valid burst; burst with backpressure
    vecs[0] = '{8'hA5, 1'b1, 8'h3C,  0, 1'b0, 8'h3C};
    vecs[1] = '{8'h03, 1'b0, 8'hAA,  0, 1'b0, 8'hAA};
    vecs[2] = '{8'h12, 1'b0, 8'h55,  0, 1'b1, 8'h55};
    vecs[3] = '{8'h34, 1'b0, 8'hC3,  0, 1'b1, 8'hC3};
    vecs[4] = '{8'h56, 1'b1, 8'h0F,  0, 1'b1, 8'h0F};
    vecs[5] = '{8'hC1, 1'b0, 8'h81,  0, 1'b0, 8'h81};
    vecs[6] = '{8'h7E, 1'b1, 8'h18, 10, 1'b0, 8'h18};

    // Reset state and release
    repeat (3) @(negedge p_clk);
    check("reset_outputs", {s_css, s_clk, s_mosi, tx_ready, rx_valid, busy}, 6'b100000);
    check("reset_rx_data", rx_data, 8'h00);
    p_rst = 1'b0;
    #1 check("ready_low_at_release", tx_ready, 1'b0);
    @(negedge p_clk);
    check("ready_after_release", tx_ready, 1'b1);

    // Table-driven transactions
    n_b = 0; gap_sum = 0; base_rx = 0; base_rise = 0;
    for (int i = 0; i < 7; i++) begin
      if (n_b == 0) begin
        base_rx   = rx_cnt;
        base_rise = rise_cnt;
        gap_sum   = 0;
      end
      if (vecs[i].gap > 0) begin
        for (int c = 0; c < 500 && !tx_ready; c++) @(negedge p_clk);
        if (!tx_ready) fail_now("gap_wait");
        for (int g = 0; g < vecs[i].gap; g++) begin
          check("gap_hold", {s_css, s_clk, busy, tx_ready}, 4'b0011);
          @(negedge p_clk);
        end
        gap_sum += vecs[i].gap;
      end
      offer(vecs[i].tx, vecs[i].last, vecs[i].miso, vecs[i].exp_rx, vecs[i].chk_gap);
      n_b++;
      if (vecs[i].last) begin
        wait_idle("txn_idle");
        check("cs_low_cycles", cs_low_len, n_b*16*DIV + (n_b-1) + gap_sum + DIV);
        check("sclk_rises", rise_cnt - base_rise, 8*n_b);
        check("rx_pulses", rx_cnt - base_rx, n_b);
        n_b = 0;
      end
    end

    // Reset after the third rising edge of 0x9F
    base_rx   = rx_cnt;
    base_rise = rise_cnt;
    offer(8'h9F, 1'b1, 8'h66, 8'h66, 1'b0);
    for (int c = 0; c < 200 && rise_cnt < base_rise + 3; c++) @(negedge p_clk);
    if (rise_cnt < base_rise + 3) fail_now("third_rise_wait");
    #2 p_rst = 1'b1;
    #1 check("midop_reset_outputs", {s_css, s_clk, s_mosi, tx_ready, rx_valid, busy}, 6'b100000);
    exp_mosi.delete();
    exp_rx.delete();
    miso_q.delete();
    acc_q.delete();
    repeat (2) @(negedge p_clk);
    check("no_rx_after_abort", rx_cnt - base_rx, 0);
    p_rst = 1'b0;
    @(negedge p_clk);
    check("ready_after_rerelease", tx_ready, 1'b1);
    base_rx   = rx_cnt;
    base_rise = rise_cnt;
    offer(8'h05, 1'b1, 8'hE7, 8'hE7, 1'b0);
    wait_idle("post_reset_idle");
    check("post_reset_cs_low", cs_low_len, 16*DIV + DIV);
    check("post_reset_rises", rise_cnt - base_rise, 8);
    check("post_reset_rx", rx_cnt - base_rx, 1);

    // Back-to-back single-byte transactions
    base_rx   = rx_cnt;
    base_rise = rise_cnt;
    offer(8'h9E, 1'b1, 8'h42, 8'h42, 1'b0);
    offer(8'h0B, 1'b1, 8'h99, 8'h99, 1'b0);
    check("cs_idle_gap_ok", cs_high_len >= 4, 1'b1);
    wait_idle("b2b_idle");
    check("b2b_rises", rise_cnt - base_rise, 16);
    check("b2b_rx", rx_cnt - base_rx, 2);

    // CLK_DIV=1: byte time 16 cycles, flash drives all ones
    tx_valid1 = 1'b1;
    tx_data1  = 8'h5A;
    tx_last1  = 1'b1;
    for (int c = 0; c < 50 && !tx_ready1; c++) @(negedge p_clk);
    if (!tx_ready1) fail_now("div1_accept_wait");
    @(posedge p_clk);
    t0 = $time;
    @(negedge p_clk);
    tx_valid1 = 1'b0;
    lo1 = 0; ri1 = 0; prev1 = 1'b0; mosi1 = 8'h00; t_rx = 0;
    for (int c = 0; c < 200 && busy1; c++) begin
      if (!s_css1) lo1++;
      if (s_clk1 && !prev1) begin
        ri1++;
        mosi1 = {mosi1[6:0], s_mosi1};
      end
      prev1 = s_clk1;
      if (rx_valid1) begin
        t_rx = $time - PER/2;
        check("div1_rx_data", rx_data1, 8'hFF);
      end
      @(negedge p_clk);
    end
    if (busy1) fail_now("div1_idle");
    check("div1_byte_time", 32'((t_rx - t0) / PER), 16);
    check("div1_rises", ri1, 8);
    check("div1_mosi", mosi1, 8'h5A);
    check("div1_cs_low", lo1, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(PER * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
